// File: rtl/versatile_mem_ctrl_burst_seq.sv
// rtl/versatile_mem_ctrl_burst_seq.sv - DDR2 burst data sequencer between Tx/Rx FIFOs and the I/O stage
module versatile_mem_ctrl_burst_seq #(
    parameter int RX_DLY    = 2,
    parameter int WIN_DEPTH = 16
) (
    input  logic        sdram_clk_0,
    input  logic        wb_rst,
    input  logic        cmd_wr_i,
    input  logic        cmd_rd_i,
    input  logic        bl8_i,
    input  logic [2:0]  rl_i,
    input  logic [35:0] tx_fifo_dat_i,
    input  logic        tx_fifo_empty_i,
    output logic        tx_fifo_rd_o,
    output logic [35:0] tx_dat_o,
    output logic        dq_en_o,
    output logic        dqm_en_o,
    input  logic [35:0] rx_dat_i,
    output logic [31:0] rx_fifo_dat_o,
    output logic        rx_fifo_wr_o,
    output logic        busy_o,
    output logic        underrun_o,
    output logic        cmd_err_o
);

    // Bit k of each window register describes the cycle k clocks from now:
    // en = DQ drive cycle, pop = Tx FIFO pop cycle, smp = rx capture cycle.
    logic [WIN_DEPTH-1:0] en_q, en_d;
    logic [WIN_DEPTH-1:0] pop_q, pop_d;
    logic [WIN_DEPTH-1:0] smp_q, smp_d;
    logic [35:0]          tx_dat_q, tx_dat_d;
    logic                 dqm_q, dqm_d;
    logic                 rx_wr_q, rx_wr_d;
    logic [31:0]          rx_dat_q, rx_dat_d;
    logic                 busy_q, busy_d;
    logic                 underrun_q, underrun_d;
    logic                 err_q, err_d;
    // Remaining cycles during which a same-type command is too early.
    logic [1:0]           wr_hold_q, wr_hold_d;
    logic [1:0]           rd_hold_q, rd_hold_d;

    logic [2:0]           rl_eff;
    logic [2:0]           wr_off;
    logic [4:0]           rd_off;
    logic [WIN_DEPTH-1:0] en_mask;
    logic [WIN_DEPTH-1:0] burst_mask;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 err_now;
    logic                 unused_rx_bits;

    assign unused_rx_bits = ^rx_dat_i[3:0];

    // Window scheduling, command legality, and the registered data paths.
    always_comb begin
        rl_eff     = (rl_i < 3'd3) ? 3'd3 : rl_i;
        // Next-state bit 0 is the cycle after the command; preamble sits at T+WL-1 = T+RL-2.
        wr_off     = rl_eff - 3'd3;
        // Capture cycle is one before the push at T+RL+RX_DLY.
        rd_off     = 5'(rl_eff) + 5'(RX_DLY) - 5'd2;
        en_mask    = bl8_i ? {{(WIN_DEPTH-5){1'b0}}, 5'b11111} : {{(WIN_DEPTH-5){1'b0}}, 5'b00111};
        burst_mask = bl8_i ? {{(WIN_DEPTH-4){1'b0}}, 4'b1111}  : {{(WIN_DEPTH-4){1'b0}}, 4'b0011};

        wr_ok   = cmd_wr_i & ~cmd_rd_i & (wr_hold_q == 2'd0);
        rd_ok   = cmd_rd_i & ~cmd_wr_i & (rd_hold_q == 2'd0);
        err_now = (cmd_wr_i & cmd_rd_i)
                | (cmd_wr_i & ~cmd_rd_i & (wr_hold_q != 2'd0))
                | (cmd_rd_i & ~cmd_wr_i & (rd_hold_q != 2'd0));

        en_d  = {1'b0, en_q[WIN_DEPTH-1:1]};
        pop_d = {1'b0, pop_q[WIN_DEPTH-1:1]};
        smp_d = {1'b0, smp_q[WIN_DEPTH-1:1]};
        if (wr_ok) begin
            en_d  = en_d  | (en_mask << wr_off);
            pop_d = pop_d | (burst_mask << wr_off);
        end
        if (rd_ok) begin
            smp_d = smp_d | (burst_mask << rd_off);
        end

        wr_hold_d = wr_ok ? (bl8_i ? 2'd3 : 2'd1) : ((wr_hold_q != 2'd0) ? wr_hold_q - 2'd1 : 2'd0);
        rd_hold_d = rd_ok ? (bl8_i ? 2'd3 : 2'd1) : ((rd_hold_q != 2'd0) ? rd_hold_q - 2'd1 : 2'd0);
        err_d     = err_q | err_now;

        // A pop cycle loads the next data word; an enable cycle not fed by a pop is a preamble.
        tx_dat_d   = tx_dat_q;
        dqm_d      = 1'b0;
        underrun_d = underrun_q;
        if (pop_q[0]) begin
            dqm_d    = tx_fifo_empty_i;
            tx_dat_d = tx_fifo_empty_i ? 36'h0 : tx_fifo_dat_i;
            if (tx_fifo_empty_i) begin
                underrun_d = 1'b1;
            end
        end else if (en_d[0]) begin
            tx_dat_d = 36'h0;
            dqm_d    = 1'b1;
        end

        rx_wr_d  = smp_q[0];
        rx_dat_d = smp_q[0] ? rx_dat_i[35:4] : rx_dat_q;
        busy_d   = (|en_d) | (|pop_d) | (|smp_d) | rx_wr_d;
    end

    // State register; reset drops all in-flight bursts and clears the sticky flags.
    always_ff @(posedge sdram_clk_0) begin
        if (wb_rst) begin
            en_q       <= '0;
            pop_q      <= '0;
            smp_q      <= '0;
            tx_dat_q   <= 36'h0;
            dqm_q      <= 1'b0;
            rx_wr_q    <= 1'b0;
            rx_dat_q   <= 32'h0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;
            wr_hold_q  <= 2'd0;
            rd_hold_q  <= 2'd0;
        end else begin
            en_q       <= en_d;
            pop_q      <= pop_d;
            smp_q      <= smp_d;
            tx_dat_q   <= tx_dat_d;
            dqm_q      <= dqm_d;
            rx_wr_q    <= rx_wr_d;
            rx_dat_q   <= rx_dat_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            err_q      <= err_d;
            wr_hold_q  <= wr_hold_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    assign tx_fifo_rd_o  = pop_q[0] & ~tx_fifo_empty_i;
    assign tx_dat_o      = tx_dat_q;
    assign dq_en_o       = en_q[0];
    assign dqm_en_o      = dqm_q;
    assign rx_fifo_dat_o = rx_dat_q;
    assign rx_fifo_wr_o  = rx_wr_q;
    assign busy_o        = busy_q;
    assign underrun_o    = underrun_q;
    assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_versatile_mem_ctrl_burst_seq.sv
// tb/tb_versatile_mem_ctrl_burst_seq.sv - self-checking bench for versatile_mem_ctrl_burst_seq
module tb_versatile_mem_ctrl_burst_seq;

    localparam int RX_DLY = 2;
    localparam int MAXC   = 4096;

    logic        sdram_clk_0 = 1'b0;
    logic        wb_rst, cmd_wr_i, cmd_rd_i, bl8_i;
    logic [2:0]  rl_i;
    logic [35:0] tx_fifo_dat_i;
    logic        tx_fifo_empty_i;
    logic        tx_fifo_rd_o;
    logic [35:0] tx_dat_o;
    logic        dq_en_o, dqm_en_o;
    logic [35:0] rx_dat_i;
    logic [31:0] rx_fifo_dat_o;
    logic        rx_fifo_wr_o, busy_o, underrun_o, cmd_err_o;

    always #5 sdram_clk_0 = ~sdram_clk_0;

    versatile_mem_ctrl_burst_seq #(.RX_DLY(RX_DLY), .WIN_DEPTH(16)) dut (
        .sdram_clk_0(sdram_clk_0), .wb_rst(wb_rst), .cmd_wr_i(cmd_wr_i), .cmd_rd_i(cmd_rd_i),
        .bl8_i(bl8_i), .rl_i(rl_i), .tx_fifo_dat_i(tx_fifo_dat_i), .tx_fifo_empty_i(tx_fifo_empty_i),
        .tx_fifo_rd_o(tx_fifo_rd_o), .tx_dat_o(tx_dat_o), .dq_en_o(dq_en_o), .dqm_en_o(dqm_en_o),
        .rx_dat_i(rx_dat_i), .rx_fifo_dat_o(rx_fifo_dat_o), .rx_fifo_wr_o(rx_fifo_wr_o),
        .busy_o(busy_o), .underrun_o(underrun_o), .cmd_err_o(cmd_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: per-absolute-cycle burst calendar plus an external FIFO queue.
    logic [35:0] txq[$];
    bit          m_en[MAXC];
    bit          m_pop[MAXC];
    bit          m_smp[MAXC];
    logic [35:0] m_tx;
    logic        m_dqm, m_rxwr, m_under, m_err;
    logic [31:0] m_rxdat;
    int          wr_free, rd_free;
    logic        exp_dq_en, exp_rd, exp_busy;

    task automatic drive_fifo();
        tx_fifo_empty_i = (txq.size() == 0);
        tx_fifo_dat_i   = (txq.size() != 0) ? txq[0] : 36'h0;
    endtask

    task automatic model_update();
        int c, n, rl;
        c = cyc;
        if (wb_rst) begin
            for (int i = 0; i < MAXC; i++) begin
                m_en[i] = 0; m_pop[i] = 0; m_smp[i] = 0;
            end
            m_tx = 36'h0; m_dqm = 0; m_rxwr = 0; m_rxdat = 32'h0; m_under = 0; m_err = 0;
            wr_free = 0; rd_free = 0;
        end else begin
            n  = bl8_i ? 4 : 2;
            rl = (rl_i < 3) ? 3 : int'(rl_i);
            if (cmd_wr_i && cmd_rd_i) begin
                m_err = 1;
            end else if (cmd_wr_i) begin
                if (c < wr_free) m_err = 1;
                else begin
                    // WL = RL-1: preamble at T+WL-1, data T+WL..T+WL+N-1, pops one cycle ahead of data
                    for (int k = rl - 2; k <= rl + n - 2; k++) m_en[c + k] = 1;
                    for (int k = rl - 2; k <= rl + n - 3; k++) m_pop[c + k] = 1;
                    wr_free = c + n;
                end
            end else if (cmd_rd_i) begin
                if (c < rd_free) m_err = 1;
                else begin
                    // pushes at T+RL+RX_DLY.., each one cycle after its capture
                    for (int k = rl + RX_DLY - 1; k <= rl + RX_DLY + n - 2; k++) m_smp[c + k] = 1;
                    rd_free = c + n;
                end
            end
            if (m_pop[c]) begin
                if (txq.size() != 0) begin
                    m_tx = txq.pop_front(); m_dqm = 0;
                end else begin
                    m_tx = 36'h0; m_dqm = 1; m_under = 1;
                end
            end else if (m_en[c + 1]) begin
                m_tx = 36'h0; m_dqm = 1;
            end else begin
                m_dqm = 0;
            end
            m_rxwr = m_smp[c];
            if (m_smp[c]) m_rxdat = rx_dat_i[35:4];
        end
    endtask

    // Ends the current cycle and leaves the bench at the falling edge of the next one.
    task automatic tick();
        @(posedge sdram_clk_0);
        model_update();
        #1;
        cyc++;
        cmd_wr_i = 0;
        cmd_rd_i = 0;
        rx_dat_i = (36'(cyc) << 4) | 36'($urandom_range(0, 15));
        drive_fifo();
        @(negedge sdram_clk_0);
        exp_dq_en = m_en[cyc];
        exp_rd    = m_pop[cyc] && (txq.size() != 0);
        exp_busy  = m_rxwr;
        for (int i = cyc; i < cyc + 24; i++) if (m_en[i] || m_pop[i] || m_smp[i]) exp_busy = 1;
    endtask

    task automatic do_reset();
        wb_rst = 1; cmd_wr_i = 0; cmd_rd_i = 0;
        txq.delete(); drive_fifo();
        tick(); tick();
        wb_rst = 0;
    endtask

    task automatic test_reset();
        wb_rst = 1; cmd_wr_i = 1; cmd_rd_i = 0; bl8_i = 1; rl_i = 3'd3;
        tick();
        wb_rst = 0;
        n_tests++; if ({dq_en_o, dqm_en_o, tx_fifo_rd_o, rx_fifo_wr_o, busy_o, underrun_o, cmd_err_o} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0", {dq_en_o, dqm_en_o, tx_fifo_rd_o, rx_fifo_wr_o, busy_o, underrun_o, cmd_err_o}); end
        n_tests++; if (tx_dat_o !== 36'h0) begin n_fail++; $display("FAIL reset_tx_dat got=%h exp=0", tx_dat_o); end
        n_tests++; if (rx_fifo_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_rx_dat got=%h exp=0", rx_fifo_dat_o); end
        tick();
        n_tests++; if (dq_en_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ignored dq_en=%b busy=%b exp=0", dq_en_o, busy_o); end
    endtask

    task automatic test_write_basic();
        logic [35:0] a, b;
        int n_en, n_pop;
        do_reset();
        a = {$urandom, 4'h5}; b = {$urandom, 4'ha};
        txq.push_back(a); txq.push_back(b); drive_fifo();
        tick(); tick();
        cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd3;
        n_en = 0; n_pop = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++; if (dq_en_o !== exp_dq_en) begin n_fail++; $display("FAIL wr_dq_en i=%0d got=%b exp=%b", i, dq_en_o, exp_dq_en); end
            n_tests++; if (dqm_en_o !== m_dqm) begin n_fail++; $display("FAIL wr_dqm i=%0d got=%b exp=%b", i, dqm_en_o, m_dqm); end
            n_tests++; if (tx_fifo_rd_o !== exp_rd) begin n_fail++; $display("FAIL wr_pop i=%0d got=%b exp=%b", i, tx_fifo_rd_o, exp_rd); end
            n_tests++; if (tx_dat_o !== m_tx) begin n_fail++; $display("FAIL wr_tx_dat i=%0d got=%h exp=%h", i, tx_dat_o, m_tx); end
            if (dq_en_o === 1'b1) n_en++;
            if (tx_fifo_rd_o === 1'b1) n_pop++;
            if (i == 1) begin
                n_tests++; if ({dq_en_o, dqm_en_o, tx_fifo_rd_o} !== 3'b111) begin n_fail++; $display("FAIL wr_preamble got=%b exp=111", {dq_en_o, dqm_en_o, tx_fifo_rd_o}); end
            end
            if (i == 2) begin
                n_tests++; if (tx_dat_o !== a || dqm_en_o !== 1'b0) begin n_fail++; $display("FAIL wr_word_a got=%h/%b exp=%h/0", tx_dat_o, dqm_en_o, a); end
            end
            if (i == 3) begin
                n_tests++; if (tx_dat_o !== b) begin n_fail++; $display("FAIL wr_word_b got=%h exp=%h", tx_dat_o, b); end
            end
        end
        n_tests++; if (n_en != 3 || n_pop != 2) begin n_fail++; $display("FAIL wr_counts en=%0d pop=%0d exp 3/2", n_en, n_pop); end
        n_tests++; if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL wr_no_underrun got=%b exp=0", underrun_o); end
    endtask

    task automatic test_underrun();
        do_reset();
        txq.push_back({$urandom, 4'h1}); txq.push_back({$urandom, 4'h2}); drive_fifo();
        tick();
        cmd_wr_i = 1; bl8_i = 1; rl_i = 3'd5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++; if (dq_en_o !== exp_dq_en || dqm_en_o !== m_dqm) begin n_fail++; $display("FAIL ur_en_dqm i=%0d got=%b%b exp=%b%b", i, dq_en_o, dqm_en_o, exp_dq_en, m_dqm); end
            n_tests++; if (tx_dat_o !== m_tx) begin n_fail++; $display("FAIL ur_tx_dat i=%0d got=%h exp=%h", i, tx_dat_o, m_tx); end
            n_tests++; if (tx_fifo_rd_o !== exp_rd) begin n_fail++; $display("FAIL ur_pop i=%0d got=%b exp=%b", i, tx_fifo_rd_o, exp_rd); end
            if (i == 6 || i == 7) begin
                n_tests++; if (dqm_en_o !== 1'b1 || tx_dat_o !== 36'h0) begin n_fail++; $display("FAIL ur_masked i=%0d got=%b/%h exp=1/0", i, dqm_en_o, tx_dat_o); end
            end
        end
        n_tests++; if (underrun_o !== 1'b1) begin n_fail++; $display("FAIL ur_sticky got=%b exp=1", underrun_o); end
        do_reset();
        n_tests++; if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL ur_cleared got=%b exp=0", underrun_o); end
    endtask

    task automatic test_read();
        int t0, first, n_push;
        do_reset();
        tick();
        t0 = cyc; cmd_rd_i = 1; bl8_i = 1; rl_i = 3'd4;
        first = -1; n_push = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            n_tests++; if (rx_fifo_wr_o !== m_rxwr) begin n_fail++; $display("FAIL rd_push i=%0d got=%b exp=%b", i, rx_fifo_wr_o, m_rxwr); end
            n_tests++; if (rx_fifo_dat_o !== m_rxdat) begin n_fail++; $display("FAIL rd_dat i=%0d got=%h exp=%h", i, rx_fifo_dat_o, m_rxdat); end
            n_tests++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL rd_busy i=%0d got=%b exp=%b", i, busy_o, exp_busy); end
            if (rx_fifo_wr_o === 1'b1) begin
                if (first < 0) first = cyc - t0;
                n_push++;
                // pushed word is the capture from the previous cycle, which carried cyc-1 in its upper bits
                n_tests++; if (rx_fifo_dat_o !== 32'(cyc - 1)) begin n_fail++; $display("FAIL rd_word i=%0d got=%h exp=%h", i, rx_fifo_dat_o, 32'(cyc - 1)); end
            end
            if (i == 10) begin
                n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rd_busy_fall got=%b exp=0", busy_o); end
            end
        end
        n_tests++; if (first != 6 || n_push != 4) begin n_fail++; $display("FAIL rd_window first=%0d n=%0d exp 6/4", first, n_push); end
    endtask

    task automatic test_back_to_back();
        int t0, n_en, n_pop, last_en;
        do_reset();
        for (int k = 0; k < 4; k++) txq.push_back({$urandom, 4'(k)});
        drive_fifo();
        tick();
        t0 = cyc; n_en = 0; n_pop = 0; last_en = -1;
        cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd3;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 2 - 1 + 1 && cyc == t0 + 2) begin cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd3; end
            n_tests++; if (dq_en_o !== exp_dq_en || tx_fifo_rd_o !== exp_rd) begin n_fail++; $display("FAIL b2b_en_pop i=%0d got=%b%b exp=%b%b", i, dq_en_o, tx_fifo_rd_o, exp_dq_en, exp_rd); end
            n_tests++; if (tx_dat_o !== m_tx || dqm_en_o !== m_dqm) begin n_fail++; $display("FAIL b2b_data i=%0d got=%h/%b exp=%h/%b", i, tx_dat_o, dqm_en_o, m_tx, m_dqm); end
            if (dq_en_o === 1'b1) begin n_en++; last_en = i; end
            if (tx_fifo_rd_o === 1'b1) n_pop++;
        end
        n_tests++; if (n_en != 5 || last_en != 5 || n_pop != 4 || cmd_err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_seamless en=%0d last=%0d pop=%0d err=%b exp 5/5/4/0", n_en, last_en, n_pop, cmd_err_o); end

        do_reset();
        for (int k = 0; k < 4; k++) txq.push_back({$urandom, 4'(k)});
        drive_fifo();
        tick();
        cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd3;
        n_pop = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd3; end
            n_tests++; if (dq_en_o !== exp_dq_en || tx_fifo_rd_o !== exp_rd) begin n_fail++; $display("FAIL early_en_pop i=%0d got=%b%b exp=%b%b", i, dq_en_o, tx_fifo_rd_o, exp_dq_en, exp_rd); end
            if (tx_fifo_rd_o === 1'b1) n_pop++;
        end
        n_tests++; if (cmd_err_o !== 1'b1 || n_pop != 2) begin n_fail++; $display("FAIL early_err err=%b pop=%0d exp 1/2", cmd_err_o, n_pop); end
    endtask

    task automatic test_conflict();
        do_reset();
        tick();
        cmd_wr_i = 1; cmd_rd_i = 1; bl8_i = 1'($urandom_range(0, 1)); rl_i = 3'($urandom_range(0, 7));
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_tests++; if (busy_o !== 1'b0 || dq_en_o !== 1'b0 || rx_fifo_wr_o !== 1'b0) begin n_fail++; $display("FAIL conflict_idle i=%0d busy=%b en=%b wr=%b exp 0", i, busy_o, dq_en_o, rx_fifo_wr_o); end
        end
        n_tests++; if (cmd_err_o !== 1'b1) begin n_fail++; $display("FAIL conflict_err got=%b exp=1", cmd_err_o); end
    endtask

    task automatic test_reset_mid();
        int n_push;
        do_reset();
        tick();
        cmd_rd_i = 1; bl8_i = 1; rl_i = 3'd4;
        for (int i = 1; i <= 7; i++) tick();
        n_tests++; if (rx_fifo_wr_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_window got=%b exp=1", rx_fifo_wr_o); end
        wb_rst = 1;
        tick();
        wb_rst = 0;
        n_tests++; if ({rx_fifo_wr_o, busy_o, underrun_o, cmd_err_o} !== 4'b0) begin n_fail++; $display("FAIL mid_cleared got=%b exp=0000", {rx_fifo_wr_o, busy_o, underrun_o, cmd_err_o}); end
        cmd_rd_i = 1; bl8_i = 1; rl_i = 3'd4;
        n_push = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_tests++; if (rx_fifo_wr_o !== m_rxwr || rx_fifo_dat_o !== m_rxdat) begin n_fail++; $display("FAIL mid_after i=%0d got=%b/%h exp=%b/%h", i, rx_fifo_wr_o, rx_fifo_dat_o, m_rxwr, m_rxdat); end
            if (rx_fifo_wr_o === 1'b1) n_push++;
        end
        n_tests++; if (n_push != 4) begin n_fail++; $display("FAIL mid_after_count got=%0d exp=4", n_push); end
    endtask

    task automatic test_rl_low();
        logic [7:0] en_trace, push_trace;
        do_reset();
        txq.push_back({$urandom, 4'h3}); txq.push_back({$urandom, 4'h4}); drive_fifo();
        tick();
        cmd_wr_i = 1; bl8_i = 0; rl_i = 3'd1;
        en_trace = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            en_trace[i-1] = dq_en_o;
            n_tests++; if (tx_dat_o !== m_tx || dqm_en_o !== m_dqm) begin n_fail++; $display("FAIL rl1_data i=%0d got=%h/%b exp=%h/%b", i, tx_dat_o, dqm_en_o, m_tx, m_dqm); end
        end
        n_tests++; if (en_trace !== 8'b0000_0111) begin n_fail++; $display("FAIL rl1_wr_window got=%b exp=00000111", en_trace); end
        cmd_rd_i = 1; bl8_i = 0; rl_i = 3'd0;
        push_trace = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            push_trace[i-1] = rx_fifo_wr_o;
        end
        n_tests++; if (push_trace !== 8'b0011_0000) begin n_fail++; $display("FAIL rl0_rd_window got=%b exp=00110000", push_trace); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick();
            n_tests++; if (dq_en_o !== exp_dq_en || dqm_en_o !== m_dqm || tx_fifo_rd_o !== exp_rd) begin n_fail++; $display("FAIL rnd_tx_ctl cyc=%0d got=%b%b%b exp=%b%b%b", cyc, dq_en_o, dqm_en_o, tx_fifo_rd_o, exp_dq_en, m_dqm, exp_rd); end
            n_tests++; if (tx_dat_o !== m_tx) begin n_fail++; $display("FAIL rnd_tx_dat cyc=%0d got=%h exp=%h", cyc, tx_dat_o, m_tx); end
            n_tests++; if (rx_fifo_wr_o !== m_rxwr || rx_fifo_dat_o !== m_rxdat) begin n_fail++; $display("FAIL rnd_rx cyc=%0d got=%b/%h exp=%b/%h", cyc, rx_fifo_wr_o, rx_fifo_dat_o, m_rxwr, m_rxdat); end
            n_tests++; if (busy_o !== exp_busy || underrun_o !== m_under || cmd_err_o !== m_err) begin n_fail++; $display("FAIL rnd_status cyc=%0d got=%b%b%b exp=%b%b%b", cyc, busy_o, underrun_o, cmd_err_o, exp_busy, m_under, m_err); end
            r = $urandom_range(0, 15);
            cmd_wr_i = (r == 0) || (r >= 1 && r <= 3);
            cmd_rd_i = (r == 0) || (r >= 4 && r <= 6);
            rl_i     = 3'($urandom_range(0, 7));
            bl8_i    = 1'($urandom_range(0, 1));
            wb_rst   = ($urandom_range(0, 199) == 0);
            if (txq.size() < 6 && $urandom_range(0, 2) == 0) txq.push_back({$urandom, 4'($urandom_range(0, 15))});
            drive_fifo();
        end
        wb_rst = 0;
    endtask

    initial begin
        wb_rst = 1; cmd_wr_i = 0; cmd_rd_i = 0; bl8_i = 0; rl_i = 3'd3;
        rx_dat_i = 36'h0;
        drive_fifo();
        test_reset();
        test_write_basic();
        test_underrun();
        test_read();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        test_rl_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/versatile_mem_ctrl_burst_seq.md
Name: versatile_mem_ctrl_burst_seq

Overview:
- Burst data sequencer between the controller's Tx/Rx FIFOs and the DDR2 I/O stage.
- On each WRITE command it pops burst data from the Tx FIFO and drives the I/O stage's 36-bit tx data word, with the data and mask enables aligned to write latency.
- On each READ command it harvests captured read data from the I/O stage after read latency plus capture delay, and pushes it to the Rx FIFO.
- One 36-bit word carries two 16-bit DDR beats:
  - [35:20] first beat
  - [19:4] second beat
  - [3:0] byte-mask bits

Parameters:
- RX_DLY, 2, clocks from the nominal read-data cycle (command + RL) until the captured word is valid at rx_dat_i; legal 0..4.
- WIN_DEPTH, 16, length of the internal write/read window shift registers; must be ≥ 7+RX_DLY+4.

Ports:
- sdram_clk_0  in  1  sole clock; all logic on the rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- cmd_wr_i  in  1  one-cycle pulse, coincident with a WRITE command on the SDRAM bus.
- cmd_rd_i  in  1  one-cycle pulse, coincident with a READ command.
- bl8_i  in  1  burst length, sampled with the command: 1 = BL8 (N=4 words), 0 = BL4 (N=2 words).
- rl_i  in  3  read latency RL (CL+AL) in clocks, sampled with the command. Values 0..2 are treated as 3. WL = RL-1.
- tx_fifo_dat_i  in  36  show-ahead Tx FIFO head word.
- tx_fifo_empty_i  in  1  Tx FIFO empty.
- tx_fifo_rd_o  out  1  Tx FIFO pop.
- tx_dat_o  out  36  word to the I/O stage.
- dq_en_o  out  1  DQ/DQS/DM output-drive and DDR-output-flop enable.
- dqm_en_o  out  1  force-mask: masks all bytes of the current word.
- rx_dat_i  in  36  captured read word from the I/O stage.
- rx_fifo_dat_o  out  32  word to the Rx FIFO: rx_dat_i[35:4].
- rx_fifo_wr_o  out  1  Rx FIFO push.
- busy_o  out  1  any burst pending or in progress.
- underrun_o  out  1  sticky: Tx FIFO empty when data was required.
- cmd_err_o  out  1  sticky: illegal command timing.

Behaviour:
- Reset (sync, wb_rst=1 at a rising edge):
  - All outputs 0, tx_dat_o = 36'h0, both sticky flags cleared.
  - Window shift registers cleared, so in-flight bursts are dropped.
  - Commands in the reset cycle are ignored.
- Write window for a WRITE at cycle T, with N = 2 or 4 and WL = RL-1:
  - Preamble cycle P = T+WL-1.
  - Data cycles T+WL .. T+WL+N-1.
  - dq_en_o = 1 for cycles P .. T+WL+N-1 (N+1 cycles).
  - In P, dqm_en_o = 1 and tx_dat_o = 0.
- Registered data path:
  - tx_fifo_rd_o is combinational: asserted in each cycle T+WL-1 .. T+WL+N-2 when tx_fifo_empty_i = 0.
  - In those same cycles, tx_dat_o <= tx_fifo_dat_i and dqm_en_o <= tx_fifo_empty_i.
  - Net effect: each data word appears on tx_dat_o in its data cycle.
- Tx underrun: if the FIFO is empty in a pop cycle:
  - no pop;
  - tx_dat_o <= 0 and dqm_en_o <= 1 for that data cycle;
  - underrun_o <= 1 (sticky);
  - the burst continues; there is no re-alignment.
- Outside write windows: dq_en_o = 0, dqm_en_o = 0, tx_dat_o holds its last value.
- Read window for a READ at cycle T: rx_fifo_wr_o = 1 for cycles T+RL+RX_DLY .. T+RL+RX_DLY+N-1, with rx_fifo_dat_o = rx_dat_i[35:4] registered from the same-cycle input (so push and data are coincident, one cycle after rx_dat_i is sampled; RX_DLY is calibrated for this).
- Window implementation:
  - Each command ORs N bits into a write or read shift register at the offset given by the latency sampled with that command. The registers shift by one each clock.
  - Back-to-back same-type commands spaced exactly N cycles apart produce seamless windows; no preamble is inserted between write bursts, and the preamble bit of the second write overlaps the last data cycle of the first.
- Command errors: each of the following sets cmd_err_o and is otherwise ignored (the earlier window is unaffected):
  - cmd_wr_i and cmd_rd_i both high in one cycle;
  - a same-type command less than N (of the previous command) cycles after the previous one.
- busy_o = OR of all window bits, registered.
- Write-to-read bus turnaround is the command scheduler's responsibility and is not checked here.
- Reset has priority over all events in the same cycle.

Test Plan:
- Reset, then RL=3 BL4 WRITE at T=10 with the FIFO preloaded with A,B → dq_en_o high at cycles 11,12,13; dqm_en_o high only at 11; tx_fifo_rd_o at 11,12; tx_dat_o = A at 12 and B at 13; underrun_o = 0.
- RL=5 BL8 WRITE with the FIFO holding 2 words → words 1 and 2 output; cycles for words 3 and 4 show dqm_en_o = 1 and tx_dat_o = 0; underrun_o = 1 and stays set until reset.
- RL=4 RX_DLY=2 BL8 READ at T=20, rx_dat_i incrementing 36'h10,36'h20,… per cycle → rx_fifo_wr_o high at cycles 26..29 with rx_fifo_dat_o = rx_dat_i[35:4] of the value sampled in cycles 25..28; busy_o falls after cycle 29.
- Two BL4 WRITEs at T and T+2 (RL=3) → dq_en_o continuous for 5 cycles, four pops, no gap; second WRITE at T+1 → cmd_err_o = 1, only 2 pops.
- cmd_wr_i and cmd_rd_i high together → no window, busy_o stays 0, cmd_err_o = 1.
- wb_rst asserted in the middle of a BL8 read window → next cycle rx_fifo_wr_o = 0, busy_o = 0, flags clear; a new READ after reset completes normally.
- rl_i = 1 → timing identical to rl_i = 3.
